// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target that ACKs a 7-bit address and moves bytes to/from a byte interface
//
// Ports:
//   clock      system clock, at least 10x the SCL rate
//   Reset      asynchronous, active-high
//   SCL        bus clock from the pad (never driven here)
//   SDAIn      bus data from the pad
//   SDAOutLow  1 pulls SDA low; 0 releases the open-drain pad
//   RxData     last received write byte
//   RxValid    one-cycle pulse when RxData is new
//   TxData     byte to send on a read
//   TxRequest  one-cycle pulse asking the provider for the next TxData
//   Busy       high from START to STOP
//   AddrMatch  high while the current transaction addresses this target
//
// Build option: define I2C_TARGET_READ_EN to support read transactions.
// Without it, a read address is NACKed and TxRequest is tied 0.

module i2c_target #(
    parameter logic [6:0] ADDRESS     = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL,
    input  logic       SDAIn,
    output logic       SDAOutLow,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic [7:0] TxData,
    output logic       TxRequest,
    output logic       Busy,
    output logic       AddrMatch
);

`ifdef I2C_TARGET_READ_EN
    localparam bit READ_OK = 1'b1;
`else
    localparam bit READ_OK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        IGNORE
    } state_t;

    // Synchronisers reset to 1 so an idle bus never looks like START/STOP.
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDAIn};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    // SCL must be high in both samples so an SDA change near an SCL edge is not misread.
    assign start_det = scl_s & scl_prev & ~sda_s & sda_prev;
    assign stop_det  = scl_s & scl_prev & sda_s & ~sda_prev;

    state_t     state, state_next;
    logic [3:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift, shift_next;
    logic [7:0] rx_data, rx_data_next;
    logic       rx_valid, rx_valid_next;
    logic       sda_low, sda_low_next;
    logic       addr_match, addr_match_next;
    logic       addr_ok;

    assign addr_ok = (shift[7:1] == ADDRESS) && (shift[7:1] != 7'h00)
                     && (!shift[0] || READ_OK);

`ifdef I2C_TARGET_READ_EN
    logic       rw, rw_next;
    logic [7:0] tx_shift, tx_shift_next;
    logic       tx_req, tx_req_next;
`else
    logic       unused_tx_data;
    assign unused_tx_data = ^TxData;
`endif

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            sda_low    <= 1'b0;
            addr_match <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            rw         <= 1'b0;
            tx_shift   <= 8'h00;
            tx_req     <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            rx_data    <= rx_data_next;
            rx_valid   <= rx_valid_next;
            sda_low    <= sda_low_next;
            addr_match <= addr_match_next;
`ifdef I2C_TARGET_READ_EN
            rw         <= rw_next;
            tx_shift   <= tx_shift_next;
            tx_req     <= tx_req_next;
`endif
        end
    end

    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift;
        rx_data_next    = rx_data;
        rx_valid_next   = 1'b0;
        sda_low_next    = sda_low;
        addr_match_next = addr_match;
`ifdef I2C_TARGET_READ_EN
        rw_next         = rw;
        tx_shift_next   = tx_shift;
        tx_req_next     = 1'b0;
`endif
        // Bus conditions take priority over any bit sampled in the same cycle.
        if (start_det) begin
            state_next      = ADDR;
            bit_cnt_next    = 4'd0;
            sda_low_next    = 1'b0;
            addr_match_next = 1'b0;
        end else if (stop_det) begin
            state_next      = IDLE;
            bit_cnt_next    = 4'd0;
            sda_low_next    = 1'b0;
            addr_match_next = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_next   = {shift[6:0], sda_s};
                        bit_cnt_next = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_next = 4'd0;
                        if (addr_ok) begin
                            state_next      = ADDR_ACK;
                            sda_low_next    = 1'b1;
                            addr_match_next = 1'b1;
`ifdef I2C_TARGET_READ_EN
                            rw_next         = shift[0];
`endif
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    // Entered on a fall; the next fall ends the ACK clock.
`ifdef I2C_TARGET_READ_EN
                    if (scl_rise && rw) begin
                        tx_req_next = 1'b1;
                    end else if (scl_fall) begin
                        if (rw) begin
                            state_next    = TX_BYTE;
                            tx_shift_next = TxData;
                            sda_low_next  = ~TxData[7];
                        end else begin
                            state_next    = RX_BYTE;
                            sda_low_next  = 1'b0;
                        end
                    end
`else
                    if (scl_fall) begin
                        state_next   = RX_BYTE;
                        sda_low_next = 1'b0;
                    end
`endif
                end
                RX_BYTE: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_next   = {shift[6:0], sda_s};
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_next  = {shift[6:0], sda_s};
                            rx_valid_next = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_next   = RX_ACK;
                        bit_cnt_next = 4'd0;
                        sda_low_next = 1'b1;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_next   = RX_BYTE;
                        sda_low_next = 1'b0;
                    end
                end
`ifdef I2C_TARGET_READ_EN
                TX_BYTE: begin
                    // The initiator samples on the rise; the next bit moves to
                    // bit 7 then and is driven at the following fall.
                    if (scl_rise && bit_cnt != 4'd8) begin
                        tx_shift_next = {tx_shift[6:0], 1'b0};
                        bit_cnt_next  = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_next   = TX_ACK;
                            bit_cnt_next = 4'd0;
                            sda_low_next = 1'b0;
                        end else begin
                            sda_low_next = ~tx_shift[7];
                        end
                    end
                end
                TX_ACK: begin
                    // bit_cnt=1 records that the initiator ACKed on the rise.
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_next = IGNORE;
                        end else begin
                            tx_req_next  = 1'b1;
                            bit_cnt_next = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_next    = TX_BYTE;
                        bit_cnt_next  = 4'd0;
                        tx_shift_next = TxData;
                        sda_low_next  = ~TxData[7];
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign SDAOutLow = sda_low;
    assign RxData    = rx_data;
    assign RxValid   = rx_valid;
    assign Busy      = (state != IDLE);
    assign AddrMatch = addr_match;
`ifdef I2C_TARGET_READ_EN
    assign TxRequest = tx_req;
`else
    assign TxRequest = 1'b0;
`endif

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) that answers the bus transactions our initiator-side controller generates. It oversamples SCL/SDA in the `clock` domain and detects START and STOP conditions. It matches a 7-bit address and ACKs it, then deserialises write bytes or serialises read bytes. It sits between the board pins (open-drain SDA pad) and a byte-wide register or peripheral interface, and is used to loop-test the initiator and to emulate sensor devices.

## Interface
Parameters:
- ADDRESS, 7'h48, 7-bit target address that is ACKed.
- SYNC_STAGES, 2, synchroniser depth on SCL and SDA (minimum 2).

Ports:
- clock  input  1  system clock, at least 10x the SCL rate.
- Reset  input  1  asynchronous, active-high.
- SCL  input  1  bus clock from pad; the target never drives it.
- SDAIn  input  1  bus data from pad.
- SDAOutLow  output  1  pulls SDA low when 1; the pad is open-drain (0 = release).
- RxData  output  8  last received write byte.
- RxValid  output  1  one-cycle pulse; RxData is new.
- TxData  input  8  byte to send on a read.
- TxRequest  output  1  one-cycle pulse; the provider must present the next TxData.
- Busy  output  1  high from START to STOP.
- AddrMatch  output  1  high while the current transaction addresses this target.

## Operation
Input conditioning:
- SCL and SDA pass through SYNC_STAGES flops, then a 1-flop edge detector.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- START and STOP are checked in every state, ahead of bit handling.

Bit rules:
- Data is sampled on the detected SCL rise.
- SDAOutLow changes only on the detected SCL fall.
- A 4-bit bit counter counts 0..8.

States:
- Idle: waits for START.
- Address: shifts 8 bits MSB-first (7 address bits + R/W).
  - Match → AddrAck.
  - Mismatch → Ignore.
- AddrAck: SDAOutLow=1 from the fall after bit 8 until the next fall.
  - R/W=0 → RxByte.
  - R/W=1 → TxByte.
- RxByte: shifts 8 bits, updates RxData, pulses RxValid → RxAck.
- RxAck: drives ACK for one SCL clock → RxByte.
- TxByte: drives bit 7..0 of the latched TxData; SDAOutLow = ~bit → TxAck.
- TxAck: releases SDA and samples the initiator's ACK on the SCL rise.
  - 0 (ACK) → TxByte with the next byte.
  - 1 (NACK) → Ignore.
- Ignore: drives nothing; waits for START or STOP.

Boundary conditions:
- START in any state (repeated start) → Address; bit counter cleared, SDA released, AddrMatch cleared.
- STOP in any state → Idle; SDA released; Busy=0, AddrMatch=0. A partial byte is discarded with no RxValid.
- Address 7'h00 (general call) is not matched.
- Simultaneous START and bit sample in the same cycle: START wins.
- Reset mid-ACK releases SDA immediately (asynchronous).

## Timing
- Reset values: SDAOutLow=0, RxData=8'h00, RxValid=0, TxRequest=0, Busy=0, AddrMatch=0, state Idle.
- Pad-to-detect latency: SYNC_STAGES+1 clock cycles.
- RxValid pulses in the cycle after the 8th data bit's SCL rise is detected.
- TxRequest pulses at the SCL rise of the address-ACK and at the SCL rise of each initiator ACK. TxData is latched at the following detected SCL fall, half an SCL period later.
- SDAOutLow transitions occur SYNC_STAGES+1 cycles after the pad SCL fall, inside the SCL low phase.
- Busy rises the cycle after START is detected and falls the cycle after STOP is detected.

## Configuration
- I2C_TARGET_READ_EN defined: read transactions are supported as described above.
- I2C_TARGET_READ_EN undefined:
  - An address with R/W=1 is NACKed and the target goes to Ignore.
  - TxByte and TxAck logic is absent; TxRequest is tied 0 and TxData is unused.

## Test plan
- Write to address 7'h48 with data 8'hA5, then STOP → ACK after the address and after the data; one RxValid pulse with RxData=8'hA5; Busy falls after STOP.
- Write to address 7'h50 → SDAOutLow stays 0 for the whole transaction; no RxValid; AddrMatch=0.
- Read from 7'h48 with TxData=8'h3C, initiator NACKs → TxRequest pulses once; SDA carries 0,0,1,1,1,1,0,0 MSB-first; SDA released afterwards; Ignore until STOP.
- Write 8'h11, then repeated START, then write to 7'h48 with 8'h22 → RxValid twice (8'h11, 8'h22); AddrMatch is re-evaluated after the restart.
- STOP after 4 data bits → no RxValid; Idle; SDAOutLow=0.
- Reset asserted during AddrAck → SDAOutLow=0 in the same cycle; all outputs at reset values; the next START is handled normally.
